// File: rtl/dlx_mem_bus_ctrl.sv
// Memory-bus master for the DLX control SM: turns MR/MW level requests into a
// req/ack bus cycle, stalls the SM via busy, and aborts on a missing ack.
module dlx_mem_bus_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MR,
    input  logic              MW,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

    state_e          state_q;
    logic [TO_W-1:0] cnt_q;

    // Combinational in IDLE so the SM stalls in the very cycle it raises a request.
    assign busy = (state_q == StIdle) ? (MR | MW) : (state_q == StWait);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            bus_err   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (MR | MW) begin
                        mem_addr  <= addr;
                        mem_wdata <= wdata;
                        mem_we    <= MW & ~MR;
                        mem_req   <= 1'b1;
                        cnt_q     <= '0;
                        if (MR & MW) bus_err <= 1'b1;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) rdata <= mem_rdata;
                        state_q <= StDone;
                    end else if (cnt_q == ToLast) begin
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        if (!mem_we) rdata <= '0;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dlx_mem_bus_ctrl.sv
// Self-checking bench for dlx_mem_bus_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_dlx_mem_bus_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          reset, MR, MW, mem_ack;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, mem_rdata;
    logic          busy, bus_err, mem_req, mem_we;
    logic [DW-1:0] rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    dlx_mem_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .reset(reset), .MR(MR), .MW(MW), .addr(addr), .wdata(wdata),
        .busy(busy), .rdata(rdata), .bus_err(bus_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: an access is either absent (waits<0), outstanding with a count of
    // WAIT cycles seen, or just finished (done) for one bus-quiet cycle.
    bit            m_valid = 0;
    int            m_waits;
    bit            m_done;
    bit            e_req, e_we, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit e_busy;
        if (m_valid) begin
            e_busy = m_done ? 1'b0 : ((m_waits >= 0) ? 1'b1 : (MR | MW));
            chk("m_busy", 64'(busy), 64'(e_busy));
            chk("m_mem_req", 64'(mem_req), 64'(e_req));
            chk("m_mem_we", 64'(mem_we), 64'(e_we));
            chk("m_mem_addr", 64'(mem_addr), 64'(e_addr));
            chk("m_mem_wdata", 64'(mem_wdata), 64'(e_wdata));
            chk("m_rdata", 64'(rdata), 64'(e_rdata));
            chk("m_bus_err", 64'(bus_err), 64'(e_err));
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_valid = 1; m_waits = -1; m_done = 0;
            e_req = 0; e_we = 0; e_err = 0; e_addr = '0; e_wdata = '0; e_rdata = '0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_waits >= 0) begin
            m_waits++;
            if (mem_ack || m_waits == int'(TO)) begin
                if (!e_we) e_rdata = mem_ack ? mem_rdata : '0;
                if (!mem_ack) e_err = 1;
                e_req = 0; m_waits = -1; m_done = 1;
            end
        end else if (MR | MW) begin
            e_addr = addr; e_wdata = wdata; e_we = MW && !MR; e_req = 1;
            if (MR && MW) e_err = 1;
            m_waits = 0;
        end
    endtask

    task automatic drive(input bit r, input bit mr, input bit mw, input bit ack,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] rd);
        reset = r; MR = mr; MW = mw; mem_ack = ack; addr = a; wdata = wd; mem_rdata = rd;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1 compare_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        drive(1, 0, 0, 0, '0, '0, '0);
        @(negedge clk);
        step(); step();
        #1;
        chk("rst_mem_req", 64'(mem_req), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_rdata", 64'(rdata), 0);
        chk("rst_bus_err", 64'(bus_err), 0);

        // Read, ack in first WAIT cycle
        drive(0, 1, 0, 0, 32'h10, 32'h0, 32'h0);
        #1 chk("t1_busy_c1", 64'(busy), 1);
        step();
        drive(0, 0, 0, 1, 32'h0, 32'h0, 32'hDEADBEEF);
        #1 chk("t1_req", 64'(mem_req), 1);
        chk("t1_we", 64'(mem_we), 0);
        chk("t1_addr", 64'(mem_addr), 64'h10);
        chk("t1_busy_c2", 64'(busy), 1);
        step();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        #1 chk("t1_busy_c3", 64'(busy), 0);
        chk("t1_rdata", 64'(rdata), 64'hDEADBEEF);
        chk("t1_req_drop", 64'(mem_req), 0);
        step();

        // Write with three wait states
        drive(0, 0, 1, 0, 32'h20, 32'h12345678, 32'h0);
        step();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("t2_we", 64'(mem_we), 1);
            chk("t2_addr", 64'(mem_addr), 64'h20);
            chk("t2_wdata", 64'(mem_wdata), 64'h12345678);
            step();
        end
        drive(0, 0, 0, 1, 32'h0, 32'h0, 32'hCAFEF00D);
        #1 chk("t2_busy_c5", 64'(busy), 1);
        step();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        #1 chk("t2_busy_done", 64'(busy), 0);
        chk("t2_rdata_kept", 64'(rdata), 64'hDEADBEEF);
        step();

        // Back-to-back reads with MR held through DONE
        drive(0, 1, 0, 0, 32'h40, 32'h0, 32'h0);
        step();
        drive(0, 1, 0, 1, 32'h40, 32'h0, 32'h11111111);
        step();
        drive(0, 1, 0, 0, 32'h44, 32'h0, 32'h0);
        #1 chk("t4_busy_done", 64'(busy), 0);
        chk("t4_rdata1", 64'(rdata), 64'h11111111);
        step();
        #1 chk("t4_busy_idle", 64'(busy), 1);
        step();
        drive(0, 1, 0, 1, 32'h44, 32'h0, 32'h22222222);
        #1 chk("t4_addr2", 64'(mem_addr), 64'h44);
        step();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        #1 chk("t4_rdata2", 64'(rdata), 64'h22222222);
        step();

        // Timeout after TO wait cycles
        drive(0, 1, 0, 0, 32'h30, 32'h0, 32'h0);
        step();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < int'(TO); i++) begin
            #1 chk("t3_req_held", 64'(mem_req), 1);
            step();
        end
        #1 chk("t3_req_drop", 64'(mem_req), 0);
        chk("t3_err", 64'(bus_err), 1);
        chk("t3_rdata", 64'(rdata), 0);
        chk("t3_busy", 64'(busy), 0);
        step(); step();
        #1 chk("t3_err_sticky", 64'(bus_err), 1);

        // Reset during WAIT, late ack afterwards
        drive(0, 1, 0, 0, 32'h50, 32'h0, 32'h0);
        step();
        drive(1, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        step();
        drive(0, 0, 0, 1, 32'h0, 32'h0, 32'h99999999);
        #1 chk("t5_req", 64'(mem_req), 0);
        chk("t5_err", 64'(bus_err), 0);
        chk("t5_busy", 64'(busy), 0);
        step();
        #1 chk("t5_rdata", 64'(rdata), 0);
        chk("t5_req_late", 64'(mem_req), 0);

        // Illegal MR&MW, then stray ack in IDLE
        drive(0, 1, 1, 0, 32'h60, 32'hAAAA5555, 32'h0);
        step();
        drive(0, 0, 0, 1, 32'h0, 32'h0, 32'h0BADF00D);
        #1 chk("t6_we", 64'(mem_we), 0);
        chk("t6_err", 64'(bus_err), 1);
        step();
        drive(0, 0, 0, 1, 32'h0, 32'h0, 32'h77777777);
        step();
        #1 chk("t6_stray_req", 64'(mem_req), 0);
        chk("t6_rdata", 64'(rdata), 64'h0BADF00D);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            drive($urandom_range(99) == 0, $urandom_range(99) < 40, $urandom_range(99) < 25,
                  $urandom_range(99) < 30, $urandom, $urandom, $urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
